// File: rtl/pwm_output_stage.sv
// 16-pin output stage: each pin is off, statically on, or driven by a shared
// PWM waveform whose duty is latched once per period from pwm_duty_cycle.
module pwm_output_stage #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  logic [7:0]  presc_reg;
  logic [7:0]  presc_next;
  logic [7:0]  cnt_reg;
  logic [7:0]  cnt_next;
  logic [7:0]  shadow_reg;
  logic [7:0]  shadow_next;
  logic [15:0] out_reg;
  logic [15:0] out_next;
  logic        period_start_reg;
  logic        period_start_next;

  logic        tick;
  logic        wrap;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // With PRESCALE = 1 the prescaler never leaves 0 and every clk is a tick.
  assign tick = (presc_reg == PRESC_LAST);
  assign wrap = tick && (cnt_reg == 8'hFF);

  // 0xFF is special-cased so full duty stays high through the counter wrap.
  assign pwm_level = (shadow_reg == 8'hFF) || (cnt_reg < shadow_reg);

  always_comb begin
    presc_next        = tick ? 8'd0 : presc_reg + 8'd1;
    cnt_next          = tick ? cnt_reg + 8'd1 : cnt_reg;
    shadow_next       = wrap ? pwm_duty_cycle : shadow_reg;
    period_start_next = wrap;
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pin
      assign out_next[gi] = en_out[gi] & (en_pwm[gi] ? pwm_level : 1'b1);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg        <= 8'd0;
      cnt_reg          <= 8'd0;
      shadow_reg       <= 8'd0;
      out_reg          <= 16'd0;
      period_start_reg <= 1'b0;
    end else begin
      presc_reg        <= presc_next;
      cnt_reg          <= cnt_next;
      shadow_reg       <= shadow_next;
      out_reg          <= out_next;
      period_start_reg <= period_start_next;
    end
  end

  assign out_7_0      = out_reg[7:0];
  assign out_15_8     = out_reg[15:8];
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage at PRESCALE 13: reset behaviour, static
// enables, duty-period high counts, shadow timing and mid-period reset.
module tb_pwm_output_stage;

  localparam int PERIOD = 256 * 13;

  logic       clk;
  logic       rst_n;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] out_7_0;
  logic [7:0] out_15_8;
  logic       period_start;

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_output_stage #(.PRESCALE(13)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out_7_0         (out_7_0),
    .out_15_8        (out_15_8),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_next_ps(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (period_start) found = 1'b1;
    end
    check(tag, int'(found), 1);
  endtask

  // Samples one full period after the current cycle; optionally rewrites the
  // duty input at sample index chg_at to exercise mid-period changes.
  task automatic measure(input int chg_at, input logic [7:0] chg_val,
                         output int hi0, output int hi15, output int rises0,
                         output int stray, output int ps_cnt,
                         output int ps_last, output int first0);
    logic prev;
    logic [15:0] o;
    hi0 = 0; hi15 = 0; rises0 = 0; stray = 0; ps_cnt = 0; ps_last = 0; first0 = 0;
    prev = out_7_0[0];
    for (int i = 0; i < PERIOD; i++) begin
      if (i == chg_at) pwm_duty_cycle = chg_val;
      @(posedge clk);
      #1;
      o = {out_15_8, out_7_0};
      if (o[0]) hi0++;
      if (o[15]) hi15++;
      if (o[0] && !prev) rises0++;
      if ((o & 16'h7FFE) != 16'd0) stray++;
      if (period_start) ps_cnt++;
      if (i == 0) first0 = int'(o[0]);
      prev = o[0];
    end
    ps_last = int'(period_start);
  endtask

  task automatic run_period(input string tag, input int chg_at, input logic [7:0] chg_val,
                            input int exp_hi, input int exp_rises, input int exp_first);
    int hi0, hi15, rises0, stray, ps_cnt, ps_last, first0;
    measure(chg_at, chg_val, hi0, hi15, rises0, stray, ps_cnt, ps_last, first0);
    check({tag, "_hi0"}, hi0, exp_hi);
    check({tag, "_hi15"}, hi15, exp_hi);
    check({tag, "_rises0"}, rises0, exp_rises);
    check({tag, "_first0"}, first0, exp_first);
    check({tag, "_stray"}, stray, 0);
    check({tag, "_ps_cnt"}, ps_cnt, 1);
    check({tag, "_ps_last"}, ps_last, 1);
    $display("period %s: hi0=%0d hi15=%0d rises=%0d first=%0d ps=%0d/%0d",
             tag, hi0, hi15, rises0, first0, ps_cnt, ps_last);
  endtask

  initial begin
    // Reset held with everything enabled: outputs must stay 0.
    rst_n = 1'b0;
    en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0 = 8'h00; en_reg_pwm_15_8 = 8'h00;
    pwm_duty_cycle = 8'hFF;
    step(3);
    check("rst_out_7_0", int'(out_7_0), 0);
    check("rst_out_15_8", int'(out_15_8), 0);
    check("rst_ps", int'(period_start), 0);
    $display("reset: out=%h%h ps=%b", out_15_8, out_7_0, period_start);

    // Release with all enables off; first wrap 3328 clks later, shadow 0x80.
    en_reg_out_7_0 = 8'h00; en_reg_out_15_8 = 8'h00;
    pwm_duty_cycle = 8'h80;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_period("idle", -1, 8'h80, 0, 0, 0);

    // Static enable on the low byte, then PWM on the high byte (level high at cnt 0).
    en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'h00;
    check("static_before_edge", int'(out_7_0), 0);
    step(1);
    check("static_out_7_0", int'(out_7_0), 8'hFF);
    check("static_out_15_8", int'(out_15_8), 8'h00);
    $display("static: out=%h%h", out_15_8, out_7_0);
    en_reg_out_7_0 = 8'h00; en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0 = 8'h00; en_reg_pwm_15_8 = 8'hFF;
    step(1);
    check("pwm_hi_out_7_0", int'(out_7_0), 8'h00);
    check("pwm_hi_out_15_8", int'(out_15_8), 8'hFF);
    $display("pwm high byte: out=%h%h", out_15_8, out_7_0);

    wait_next_ps("wait_ps_a");
    // Pins 0 and 15 in PWM mode; duty input changes mid-period are ignored.
    en_reg_out_7_0 = 8'h01; en_reg_out_15_8 = 8'h80;
    en_reg_pwm_7_0 = 8'h01; en_reg_pwm_15_8 = 8'h80;
    run_period("duty80", 0, 8'h00, 1664, 1, 1);
    run_period("duty00", 0, 8'hFF, 0, 0, 0);
    run_period("dutyFF", 0, 8'h40, PERIOD, 1, 1);
    run_period("duty40", 1000, 8'hC0, 832, 0, 1);
    run_period("dutyC0", -1, 8'hC0, 2496, 1, 1);

    // Mid-period asynchronous reset with pins active.
    step(500);
    check("pre_rst_pin0", int'(out_7_0[0]), 1);
    check("pre_rst_pin15", int'(out_15_8[7]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_7_0", int'(out_7_0), 0);
    check("async_rst_out_15_8", int'(out_15_8), 0);
    step(4);
    check("held_rst_out_7_0", int'(out_7_0), 0);
    check("held_rst_ps", int'(period_start), 0);
    $display("mid reset: out=%h%h ps=%b", out_15_8, out_7_0, period_start);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_period("post_rst", -1, 8'hC0, 0, 0, 0);
    run_period("post_rst_C0", -1, 8'hC0, 2496, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
PWM_OUTPUT_STAGE -- requirements
Module: pwm_output_stage

Interface
REQ-001 SHALL provide parameter: PRESCALE, default 13, clk cycles per PWM counter step; legal range 1..255.
REQ-002 SHALL provide ports (clock and reset first):
- clk  input  1  system clock (10 MHz nominal)
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  per-pin output enable, pins 7..0
- en_reg_out_15_8  input  8  per-pin output enable, pins 15..8
- en_reg_pwm_7_0  input  8  per-pin PWM mode select, pins 7..0
- en_reg_pwm_15_8  input  8  per-pin PWM mode select, pins 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out_7_0  output  8  registered pin drive, pins 7..0
- out_15_8  output  8  registered pin drive, pins 15..8
- period_start  output  1  one-clk pulse at start of each PWM period
REQ-003 SHALL treat all inputs as synchronous to clk; no internal synchronisers.

Function
REQ-004 SHALL contain a prescaler counter counting 0..PRESCALE-1, then wrapping to 0; "tick" = prescaler at PRESCALE-1.
REQ-005 SHALL contain an 8-bit PWM counter incrementing by 1 on each tick, wrapping 255 -> 0; unchanged between ticks.
REQ-006 PWM period SHALL be exactly 256*PRESCALE clk cycles (3328 at default).
REQ-007 SHALL hold a duty shadow register, loaded from pwm_duty_cycle only on the clk edge where the PWM counter wraps 255 -> 0.
- Mid-period changes to pwm_duty_cycle SHALL have no effect until the next period.
REQ-008 PWM level SHALL be: shadow == 0xFF -> 1 always; otherwise 1 iff PWM counter < shadow.
- Shadow 0x00 -> constant 0; shadow D in 1..254 -> high for D*PRESCALE clks per period, starting at period start.
REQ-009 Per pin i (0..15), with en_out/en_pwm the concatenated {15_8, 7_0} vectors: next out[i] = en_out[i] AND (en_pwm[i] ? PWM level : 1).
REQ-010 Outputs SHALL be registered: out reflects enables, counter and shadow as they stood before the preceding clk edge (1 clk latency).
REQ-011 Enable/mode changes SHALL take effect on the next clk edge, without waiting for a period boundary.
REQ-012 period_start SHALL be high for exactly one clk, in the cycle after the counter wraps 255 -> 0 (counter = 0, new shadow valid); low otherwise.
REQ-013 With PRESCALE = 1, tick SHALL be asserted every clk and the prescaler SHALL remain 0.
REQ-014 Simultaneous duty write and wrap edge: the shadow SHALL capture the pwm_duty_cycle value present at that edge.

Reset
REQ-015 On rst_n low, SHALL asynchronously clear the prescaler, PWM counter, shadow, out_7_0, out_15_8 and period_start to 0.
REQ-016 Reset mid-period SHALL abandon the period; after release the first period SHALL run with shadow 0, and the first wrap SHALL occur 256*PRESCALE clks after release.
REQ-017 While rst_n is low, all outputs SHALL remain 0 regardless of inputs.

Verification
REQ-018 Reset, all enables 0x00, duty 0x80 -> out_7_0 = out_15_8 = 0x00 indefinitely; period_start pulses every 3328 clks.
REQ-019 en_out 0x00FF, en_pwm 0x0000 -> out_7_0 = 0xFF 1 clk after the enable write; out_15_8 = 0x00.
REQ-020 en_out 0x0001, en_pwm 0x0001, duty 0x80, PRESCALE 13 -> from the second period onward, out_7_0[0] is high 1664 clks, low 1664 clks per period; rising edge 1 clk after period_start.
REQ-021 Duty 0x00 -> pin constantly 0; duty 0xFF -> pin constantly 1 across full periods, including the wrap.
REQ-022 Duty changed 0x40 -> 0xC0 mid-period -> current period keeps 832 high clks; next period has 2496.
REQ-023 rst_n pulsed low mid-period with pins active -> outputs 0 within the reset; after release the first period is all-low for PWM pins; the next period uses the current duty.
